uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART byte transmitter among N_REQ requesters using round-robin arbitration.
//  A requester may lock the transmitter for a multi-byte packet.
//  Sits between client logic (command responders, loopback from the receiver) and the UART TX core.
//  Issues one byte per transmitter cycle and waits for the transmitter busy flag to complete a rise/fall cycle.
// PARAMETERS
//  N_REQ       4     number of requesters (2..8)
//  BIT_MAX     8     data bits per byte (matches UART core)
//  TIMEOUT_MAX 52080 idle cycles a locked owner may stall before lock is dropped (timeout build only)
// PORTS
//  clk         in   1              system clock, rising edge
//  rst         in   1              asynchronous reset, active-high
//  req         in   N_REQ          requester k has a byte ready
//  req_data    in   N_REQ*BIT_MAX  byte of requester k at bits [k*BIT_MAX +: BIT_MAX]
//  req_last    in   N_REQ          byte of requester k is the final byte of its packet
//  gnt         out  N_REQ          one-cycle pulse: byte of requester k accepted
//  tx_start    out  1              one-cycle pulse to UART TX core
//  tx_data     out  BIT_MAX        byte to send; held stable from tx_start until tx_busy falls
//  tx_busy     in   1              UART TX core busy flag
//  owner       out  clog2(N_REQ)   index of current or last granted requester
//  arb_busy    out  1              high whenever state != IDLE
//  timeout     out  1              one-cycle pulse on forced lock release (timeout build only; else tied 0)
// BEHAVIOUR
//  Reset (async, any state):
//   - gnt, tx_start, tx_data, owner, timeout = 0; arb_busy = 0.
//   - State = IDLE; round-robin pointer ptr = 0; lock = 0.
//   - An in-flight byte is abandoned; no gnt is issued for it.
//  States: IDLE, WAIT_BUSY, WAIT_DONE, HOLD (encoded 0..3).
//  IDLE, or HOLD with req[owner], at cycle T:
//   - Winner k is the first set req at or after ptr, wrapping N_REQ-1 -> 0.
//   - In HOLD the winner is always owner.
//   - At edge T+1: gnt[k]=1, tx_start=1, tx_data=req_data[k], owner=k, lock=!req_last[k]; state -> WAIT_BUSY.
//   - gnt and tx_start drop at edge T+2.
//   - Requesters update req/req_data on seeing gnt. req is not sampled outside IDLE/HOLD.
//  WAIT_BUSY: on tx_busy=1 -> WAIT_DONE.
//  WAIT_DONE: on tx_busy=0:
//   - lock=1: -> HOLD.
//   - lock=0: ptr = owner+1 (wraps to 0); -> IDLE.
//  HOLD: other requesters are ignored; owner's next byte is granted with a one-cycle decision latency.
//  Boundary conditions:
//   - All req=0 in IDLE: stay idle, no pulses.
//   - req and req_last both set on the first byte: single-byte packet, no lock.
//   - tx_busy already 1 when entering WAIT_BUSY: advance on the next cycle.
//   - Single requester repeatedly asserting req: granted back-to-back; ptr still advances.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//   - HOLD counts cycles with req[owner]=0; counter clears on entry to HOLD and on a grant.
//   - Count reaching TIMEOUT_MAX-1: lock=0, timeout pulses 1 cycle, ptr=owner+1, -> IDLE.
//  UART_ARB_TIMEOUT_EN undefined:
//   - No counter; HOLD persists until the owner's next req.
//   - timeout tied 0.
// STRUCTURE
//  Shared package uart_pkg: BIT_MAX default, arbiter state encoding localparams, clog2 helper function.
//  Sub-module rr_pick:
//   - Combinational round-robin picker with inputs req, ptr and outputs idx, valid.
//   - Instantiated once.
//  FSM, lock, timeout counter and output registers live in the top module.
// TESTING
//  1 Reset mid-transfer: assert rst during WAIT_DONE -> all outputs 0 within the same cycle, state IDLE, ptr 0.
//  2 Single requester: req=4'b0001, data 8'h55, last=1 -> gnt=0001 and tx_start 1 cycle later,
//    tx_data=8'h55; model tx_busy 10 cycles; return to IDLE.
//  3 Fairness: req=4'b1111 held, all last=1 -> grant order 0,1,2,3,0; tx_data follows each requester's byte.
//  4 Lock: req1 sends 3 bytes AA,BB,CC (last on CC) while req=1111 -> three consecutive grants to owner 1,
//    then owner 2 is granted next.
//  5 Wrap: ptr=3, req=4'b1001 -> grant 3, then 0.
//  6 Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_MAX=16): owner 2 locked, req2=0 for 16 cycles
//    -> timeout pulse, next grant to requester 3.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   BIT_MAX_DEFAULT  default data bits per byte (matches the UART TX core)
//   arb_state_t      2-bit arbiter state type and its encodings
//   clog2()          index-width helper (never returns less than 1)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BIT_MAX_DEFAULT = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 2'd0;
    localparam arb_state_t ST_WAIT_BUSY = 2'd1;
    localparam arb_state_t ST_WAIT_DONE = 2'd2;
    localparam arb_state_t ST_HOLD      = 2'd3;

    // Width needed to index 'value' items. A minimum of 1 keeps
    // single-bit index vectors legal for the smallest configurations.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req    in   N_REQ   request vector
//   ptr    in   IDX_W   highest-priority index for this decision
//   idx    out  IDX_W   first set request at or after ptr (wrapping)
//   valid  out  1       at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    // rot[gi] is the request seen gi positions after ptr; pos[gi] is the
    // requester index it came from.
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pos [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [IDX_W:0] sum;
        assign sum     = {1'b0, ptr} + (IDX_W + 1)'(gi);
        assign pos[gi] = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
        assign rot[gi] = req[pos[gi]];
    end

    // Walk from the far end so the lowest rotated offset wins without a break.
    always_comb begin
        idx   = ptr;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx   = pos[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte transmitter among N_REQ requesters with round-robin
// arbitration. A requester whose byte is not flagged last keeps the
// transmitter locked until it sends its last byte.
//
// Ports
//   clk       in   1              system clock, rising edge
//   rst       in   1              asynchronous reset, active-high
//   req       in   N_REQ          requester k has a byte ready
//   req_data  in   N_REQ*BIT_MAX  byte of requester k at [k*BIT_MAX +: BIT_MAX]
//   req_last  in   N_REQ          byte of requester k ends its packet
//   gnt       out  N_REQ          one-cycle pulse: byte of requester k accepted
//   tx_start  out  1              one-cycle start pulse to the UART TX core
//   tx_data   out  BIT_MAX        byte to send, held until the next grant
//   tx_busy   in   1              UART TX core busy flag
//   owner     out  clog2(N_REQ)   current or last granted requester
//   arb_busy  out  1              arbiter is not idle
//   timeout   out  1              one-cycle pulse on forced lock release
//
// Build option
//   UART_ARB_TIMEOUT_EN  when defined, a locked owner that stalls for
//                        TIMEOUT_MAX cycles in HOLD loses the lock; when
//                        undefined, HOLD waits forever and timeout is 0.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int BIT_MAX     = BIT_MAX_DEFAULT,
    parameter int TIMEOUT_MAX = 52080,
    localparam int IDX_W      = clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BIT_MAX-1:0] req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         gnt,
    output logic                     tx_start,
    output logic [BIT_MAX-1:0]       tx_data,
    input  logic                     tx_busy,
    output logic [IDX_W-1:0]         owner,
    output logic                     arb_busy,
    output logic                     timeout
);

    arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               tx_start_q, tx_start_d;
    logic [BIT_MAX-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               lock_q, lock_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               grant_en;
    logic [IDX_W-1:0]   grant_idx;
    logic               owner_req;
    logic [IDX_W-1:0]   owner_inc;
    logic               tmo_fire;

    logic [BIT_MAX-1:0] req_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[gi*BIT_MAX +: BIT_MAX];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_req = req[owner_q];
    // Round-robin pointer after the owner releases: one past it, wrapping.
    assign owner_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // A grant happens only from IDLE (any requester, via the picker) or from
    // HOLD (only the lock owner; everyone else is ignored).
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = pick_idx;
        if (state_q == ST_IDLE) begin
            grant_en = pick_valid;
        end else if (state_q == ST_HOLD) begin
            grant_en  = owner_req;
            grant_idx = owner_q;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_MAX);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Counts HOLD cycles without a byte from the owner. Any other state,
    // including the cycle after a grant, leaves it at zero, so it restarts
    // on every entry to HOLD.
    assign tmo_fire = (state_q == ST_HOLD) && !owner_req &&
                      (idle_cnt_q == CNT_W'(TIMEOUT_MAX - 1));

    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == ST_HOLD) && !owner_req && !tmo_fire) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;

    // TIMEOUT_MAX only shapes the timeout build; this empty guard keeps the
    // parameter referenced so both builds share one parameter list.
    if (TIMEOUT_MAX < 2) begin : g_timeout_max_unused
    end
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = lock_q ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (grant_en) begin
                    state_d = ST_WAIT_BUSY;
                end else if (tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs and datapath next values ----
    always_comb begin
        gnt_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;

        if (grant_en) begin
            gnt_d[grant_idx] = 1'b1;
            tx_start_d       = 1'b1;
            tx_data_d        = req_bytes[grant_idx];
            owner_d          = grant_idx;
            lock_d           = !req_last[grant_idx];
        end

        // Pointer moves only when a packet finishes, so a locked packet
        // keeps the priority of its owner until its last byte is done.
        if ((state_q == ST_WAIT_DONE) && !tx_busy && !lock_q) begin
            ptr_d = owner_inc;
        end

        if (tmo_fire) begin
            lock_d    = 1'b0;
            timeout_d = 1'b1;
            ptr_d     = owner_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt      = gnt_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign owner    = owner_q;
    assign arb_busy = (state_q != ST_IDLE);
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench: per-requester byte FIFOs drive req/req_data/req_last,
// a small UART model answers tx_start with a busy pulse, and a
// transaction-level model of the arbitration rules predicts every output.
// Honours UART_ARB_TIMEOUT_EN (the DUT gets TIMEOUT_MAX = 16).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int BW   = 8;
    localparam int IW   = 2;
    localparam int TMAX = 16;
    localparam int FDEP = 2048;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic            tx_start;
    logic [BW-1:0]   tx_data;
    logic            tx_busy;
    logic [IW-1:0]   owner;
    logic            arb_busy;
    logic            timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .BIT_MAX     (BW),
        .TIMEOUT_MAX (TMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .owner    (owner),
        .arb_busy (arb_busy),
        .timeout  (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Requester FIFOs: entry = {last, data}
    logic [8:0] fifo [N][FDEP];
    int         wr [N];
    int         rd [N];

    // What the DUT saw on the last edge
    logic [N-1:0] prev_req;
    logic [N-1:0] prev_last;
    logic [7:0]   prev_data [N];

    // Arbitration model
    int       ptr_m;
    int       owner_m;
    bit       lock_m;
    bit       free_m;
    int       cnt_m;
    logic [7:0] cur_data;

    // UART model
    bit busy_m;
    bit pre_busy;
    int rise_wait;
    int hold;
    bit fall_pending;
    int d_lo, d_hi, l_lo, l_hi;

    int glog [$];
    bit tmo_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic bit quiet();
        for (int r = 0; r < N; r++) if (rd[r] != wr[r]) return 1'b0;
        return free_m && !lock_m && !busy_m && (hold == 0) && (rise_wait < 0) && !fall_pending;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        fifo[r][wr[r]] = {last, d};
        wr[r]++;
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
    endtask

    task automatic model_reset();
        ptr_m = 0; owner_m = 0; lock_m = 0; free_m = 1; cnt_m = 0; cur_data = 8'h00;
        busy_m = 0; pre_busy = 0; rise_wait = -1; hold = 0; fall_pending = 0;
    endtask

    task automatic apply_inputs();
        for (int r = 0; r < N; r++) begin
            if (rd[r] != wr[r]) begin
                req[r]               = 1'b1;
                req_data[r*BW +: BW] = fifo[r][rd[r]][7:0];
                req_last[r]          = fifo[r][rd[r]][8];
            end else begin
                req[r]               = 1'b0;
                req_data[r*BW +: BW] = 8'($urandom);
                req_last[r]          = 1'($urandom);
            end
            prev_data[r] = req_data[r*BW +: BW];
        end
        prev_req  = req;
        prev_last = req_last;
        tx_busy   = busy_m | pre_busy;
    endtask

    task automatic observe();
        int  w;
        bit  exp_tmo;
        w       = -1;
        exp_tmo = 1'b0;
        if (free_m) begin
            if (lock_m) begin
                if (prev_req[owner_m]) begin
                    w = owner_m;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_m == TMAX - 1) begin
                    exp_tmo = 1'b1;
                    lock_m  = 1'b0;
                    ptr_m   = (owner_m + 1) % N;
                    cnt_m   = 0;
                end else begin
                    cnt_m++;
                end
`endif
            end else begin
                w = pick(prev_req, ptr_m);
            end
        end
        chk("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("tx_start", 32'(tx_start), 32'(w >= 0));
        chk("timeout", 32'(timeout), 32'(exp_tmo));
        if (tx_start) glog.push_back(int'(owner));
        if (timeout) tmo_seen = 1'b1;
        if (w >= 0) begin
            owner_m   = w;
            cur_data  = prev_data[w];
            lock_m    = !prev_last[w];
            free_m    = 1'b0;
            cnt_m     = 0;
            rd[w]++;
            pre_busy  = 1'b0;
            rise_wait = $urandom_range(d_hi, d_lo);
            $display("GRANT cycle=%0d req=%0d data=%02h last=%0b", cyc, w, cur_data, prev_last[w]);
        end
        if (exp_tmo) $display("TIMEOUT cycle=%0d owner=%0d", cyc, owner_m);
        if (fall_pending) begin
            fall_pending = 1'b0;
            free_m       = 1'b1;
            cnt_m        = 0;
            if (!lock_m) ptr_m = (owner_m + 1) % N;
        end
        chk("tx_data", 32'(tx_data), 32'(cur_data));
        chk("owner", 32'(owner), 32'(owner_m));
        chk("arb_busy", 32'(arb_busy), 32'(!(free_m && !lock_m)));
    endtask

    task automatic drive();
        if (rise_wait == 0) begin
            busy_m    = 1'b1;
            hold      = $urandom_range(l_hi, l_lo);
            rise_wait = -1;
        end else if (rise_wait > 0) begin
            rise_wait--;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
                busy_m       = 1'b0;
                fall_pending = 1'b1;
            end
        end
        apply_inputs();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        observe();
        drive();
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 3000 && !quiet(); i++) step();
        chk(tag, 32'(quiet()), 32'd1);
    endtask

    task automatic wait_hold(input string tag);
        int i;
        for (i = 0; i < 200 && !(free_m && lock_m); i++) step();
        chk(tag, 32'(free_m && lock_m), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
    endtask

    initial begin
        int base;
        int first1;
        int fair_exp [5];
        fair_exp = '{0, 1, 2, 3, 0};

        for (int r = 0; r < N; r++) begin
            wr[r] = 0;
            rd[r] = 0;
        end
        model_reset();
        tmo_seen = 1'b0;
        d_lo = 0; d_hi = 2; l_lo = 1; l_hi = 5;
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        apply_inputs();
        rst = 1'b0;

        // No requests: arbiter stays idle with no pulses
        repeat (6) step();

        // Single requester, 10-cycle busy
        d_lo = 1; d_hi = 1; l_lo = 10; l_hi = 10;
        push_byte(0, 8'h55, 1'b1);
        drain("t2_drain");

        // Reset while a locked packet sits in WAIT_DONE
        push_byte(2, 8'h3C, 1'b0);
        push_byte(2, 8'hC3, 1'b1);
        begin
            int i;
            for (i = 0; i < 100 && !(busy_m && hold > 0 && hold < 9); i++) step();
            chk("t1_reach_wait_done", 32'(busy_m && hold > 0 && hold < 9), 32'd1);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        model_reset();
        d_lo = 0; d_hi = 2; l_lo = 1; l_hi = 4;
        for (int r = 0; r < N; r++) push_pkt(r, 1);
        for (int r = 0; r < N; r++) push_pkt(r, 1);
        apply_inputs();
        rst = 1'b0;

        // Fairness from ptr 0 with every request held
        base = glog.size();
        drain("t3_drain");
        for (int i = 0; i < 5; i++) chk("t3_fair_order", 32'(glog[base + i]), 32'(fair_exp[i]));

        // Locked 3-byte packet from requester 1 while all request
        base = glog.size();
        push_pkt(0, 1);
        push_byte(1, 8'hAA, 1'b0);
        push_byte(1, 8'hBB, 1'b0);
        push_byte(1, 8'hCC, 1'b1);
        push_pkt(2, 1);
        push_pkt(3, 1);
        drain("t4_drain");
        first1 = base;
        while (first1 < glog.size() && glog[first1] != 1) first1++;
        chk("t4_lock_g2", 32'(glog[first1 + 1]), 32'd1);
        chk("t4_lock_g3", 32'(glog[first1 + 2]), 32'd1);
        chk("t4_after_lock", 32'(glog[first1 + 3]), 32'd2);

        // Wrap: ptr now 3, requesters 0 and 3
        base = glog.size();
        push_pkt(0, 1);
        push_pkt(3, 1);
        drain("t5_drain");
        chk("t5_wrap_first", 32'(glog[base]), 32'd3);
        chk("t5_wrap_second", 32'(glog[base + 1]), 32'd0);

        // tx_busy already high when the grant lands
        pre_busy = 1'b1;
        d_lo = 0; d_hi = 0;
        repeat (3) step();
        push_pkt(1, 1);
        drain("pre_busy_drain");
        d_hi = 2;

        // Owner stalls in HOLD; a competing request is ignored
        base = glog.size();
        push_byte(1, 8'h11, 1'b0);
        wait_hold("hold_reach");
        push_pkt(3, 1);
        repeat (10) step();
        push_byte(1, 8'h22, 1'b1);
        drain("hold_drain");
        chk("hold_order0", 32'(glog[base]), 32'd1);
        chk("hold_order1", 32'(glog[base + 1]), 32'd1);
        chk("hold_order2", 32'(glog[base + 2]), 32'd3);

`ifdef UART_ARB_TIMEOUT_EN
        // Locked owner 2 goes silent until the lock is forced off
        push_byte(2, 8'h77, 1'b0);
        wait_hold("t6_hold_reach");
        push_pkt(3, 1);
        tmo_seen = 1'b0;
        begin
            int i;
            for (i = 0; i < 60 && !tmo_seen; i++) step();
        end
        chk("t6_timeout_seen", 32'(tmo_seen), 32'd1);
        base = glog.size();
        drain("t6_drain");
        chk("t6_next_grant", 32'(glog[base]), 32'd3);
`endif

        // Random traffic: whole packets, random UART latency and busy length
        d_lo = 0; d_hi = 2; l_lo = 1; l_hi = 5;
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(N - 1, 0);
            if ($urandom_range(7, 0) == 0 && (wr[r] - rd[r]) < 4) push_pkt(r, $urandom_range(3, 1));
            step();
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
